// File: rtl/image_writer_pkg.sv
// rtl/image_writer_pkg.sv - shared constants and types for the image writer
//
// Package img_pkg:
//   PIXELS_DEFAULT / BASE_ADDR_DEFAULT / LANES_DEFAULT : default geometry
//   PLANE_R / PLANE_G / PLANE_B : colour plane indices
//   LANE_W / PIX_W / ADDR_W      : lane, pixel and bus address widths
//   writer_state_t               : control FSM states
package img_pkg;
    localparam int PIXELS_DEFAULT = 10000;
    localparam logic [127:0] BASE_ADDR_DEFAULT = 128'd120000;
    localparam int LANES_DEFAULT = 4;

    localparam logic [1:0] PLANE_R = 2'd0;
    localparam logic [1:0] PLANE_G = 2'd1;
    localparam logic [1:0] PLANE_B = 2'd2;

    localparam int LANE_W = 32;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DUMP_RD,
        DUMP_OUT
    } writer_state_t;
endpackage

// File: rtl/image_writer_if.sv
// rtl/image_writer_if.sv - store and dump signal bundle for the image writer
//
// Signals:
//   we, addr[127:0], wd[127:0]        : vector store request (processor side)
//   busy                              : writer cannot take a store or dump start
//   dump_start, dump_ready            : dump control from the sink
//   dump_valid, dump_data[23:0], dump_done : dump pixel stream to the sink
// Modports: master (processor/sink), slave (image_writer).
interface image_writer_if;
    import img_pkg::*;

    logic                   we;
    logic [ADDR_W-1:0]      addr;
    logic [ADDR_W-1:0]      wd;
    logic                   busy;
    logic                   dump_start;
    logic                   dump_valid;
    logic                   dump_ready;
    logic [3*PIX_W-1:0]     dump_data;
    logic                   dump_done;

    modport master (
        output we, addr, wd, dump_start, dump_ready,
        input  busy, dump_valid, dump_data, dump_done
    );

    modport slave (
        input  we, addr, wd, dump_start, dump_ready,
        output busy, dump_valid, dump_data, dump_done
    );
endinterface

// File: rtl/image_writer_byte_plane_ram.sv
// rtl/image_writer_byte_plane_ram.sv - single-port synchronous byte RAM for one colour plane
//
// Ports:
//   clk          : clock, posedge active
//   we           : write wdata to mem[addr] (takes priority over re)
//   re           : load mem[addr] into rdata; rdata holds when re=0
//   addr[AW-1:0] : word address
//   wdata[7:0]   : write byte
//   rdata[7:0]   : registered read byte, one cycle latency
module byte_plane_ram
    import img_pkg::*;
#(
    parameter int DEPTH = PIXELS_DEFAULT,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/image_writer.sv
// rtl/image_writer.sv - commits 4-lane vector stores to R/G/B byte planes and streams the image out
//
// Ports:
//   clk   : clock, posedge active
//   rst_n : asynchronous active-low reset
//   bus   : image_writer_if.slave (we/addr/wd store, busy, dump_* stream)
// Build option: IMAGE_WRITER_SATURATE_EN clamps lane values above 255 to 8'hFF;
// without it the lane's low byte is stored.
module image_writer
    import img_pkg::*;
#(
    parameter int                PIXELS    = PIXELS_DEFAULT,
    parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int                LANES     = LANES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    image_writer_if.slave bus
);
    localparam int AW  = $clog2(PIXELS);
    localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_W-1:0] PIX_A     = ADDR_W'(PIXELS);
    localparam logic [ADDR_W-1:0] PIX2_A    = ADDR_W'(2 * PIXELS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(3 * PIXELS) - ADDR_W'(1);

    function automatic logic [PIX_W-1:0] lane_pix(input logic [LANE_W-1:0] v);
`ifdef IMAGE_WRITER_SATURATE_EN
        return (v > LANE_W'(255)) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
`else
        return v[PIX_W-1:0];
`endif
    endfunction

    writer_state_t    state, state_nx;
    logic [1:0]       plane_q;
    logic [AW-1:0]    offset_q;
    logic [PIX_W-1:0] lane_q [LANES];
    logic [LCW-1:0]   lane_cnt;
    logic [AW-1:0]    index_q;

    // Address decode, kept at full bus width so a huge address can never alias into range.
    logic [ADDR_W-1:0] rel, rel_off;
    logic [1:0]        plane_d;
    logic              hit, accept;

    always_comb begin
        rel     = bus.addr - BASE_ADDR;
        hit     = (bus.addr >= BASE_ADDR) && (bus.addr <= LAST_ADDR);
        plane_d = PLANE_R;
        rel_off = rel;
        if (rel < PIX_A) begin
            plane_d = PLANE_R;
            rel_off = rel;
        end else if (rel < PIX2_A) begin
            plane_d = PLANE_G;
            rel_off = rel - PIX_A;
        end else begin
            plane_d = PLANE_B;
            rel_off = rel - PIX2_A;
        end
    end

    assign accept = (state == IDLE) && bus.we && hit;

    // Lane target position; lanes that run past the plane end are dropped, never wrapped.
    logic [ADDR_W-1:0] wr_pos;
    logic              wr_ok, last_lane, last_pix;

    assign wr_pos    = ADDR_W'(offset_q) + ADDR_W'(lane_cnt);
    assign wr_ok     = wr_pos < PIX_A;
    assign last_lane = lane_cnt == LCW'(LANES - 1);
    assign last_pix  = index_q == AW'(PIXELS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        bus.busy       = 1'b0;
        bus.dump_valid = 1'b0;
        bus.dump_done  = 1'b0;
        case (state)
            IDLE: begin
                // A hitting store beats a simultaneous dump_start.
                if (accept) begin
                    state_nx = WRITE;
                end else if (bus.dump_start) begin
                    state_nx = DUMP_RD;
                end
            end
            WRITE: begin
                bus.busy = 1'b1;
                if (last_lane) begin
                    state_nx = IDLE;
                end
            end
            DUMP_RD: begin
                bus.busy = 1'b1;
                state_nx = DUMP_OUT;
            end
            DUMP_OUT: begin
                bus.busy       = 1'b1;
                bus.dump_valid = 1'b1;
                if (bus.dump_ready) begin
                    if (last_pix) begin
                        bus.dump_done = 1'b1;
                        state_nx      = IDLE;
                    end else begin
                        state_nx = DUMP_RD;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plane_q  <= PLANE_R;
            offset_q <= '0;
            lane_cnt <= '0;
            index_q  <= '0;
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        plane_q  <= plane_d;
                        offset_q <= AW'(rel_off);
                        lane_cnt <= '0;
                        for (int k = 0; k < LANES; k++) begin
                            lane_q[k] <= lane_pix(bus.wd[k*LANE_W +: LANE_W]);
                        end
                    end else if (bus.dump_start) begin
                        index_q <= '0;
                    end
                end
                WRITE: lane_cnt <= lane_cnt + 1'b1;
                DUMP_OUT: begin
                    if (bus.dump_ready && !last_pix) begin
                        index_q <= index_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Plane RAMs share address and data; only the addressed plane is write-enabled.
    logic [2:0]       ram_we;
    logic             ram_re;
    logic [AW-1:0]    ram_addr;
    logic [PIX_W-1:0] wr_byte;
    logic [PIX_W-1:0] rd_byte [3];

    always_comb begin
        ram_re   = (state == DUMP_RD);
        ram_addr = (state == WRITE) ? AW'(wr_pos) : index_q;
        wr_byte  = lane_q[lane_cnt];
        for (int p = 0; p < 3; p++) begin
            ram_we[p] = (state == WRITE) && wr_ok && (plane_q == 2'(p));
        end
    end

    for (genvar p = 0; p < 3; p++) begin : g_plane
        byte_plane_ram #(.DEPTH(PIXELS)) u_ram (
            .clk   (clk),
            .we    (ram_we[p]),
            .re    (ram_re),
            .addr  (ram_addr),
            .wdata (wr_byte),
            .rdata (rd_byte[p])
        );
    end

    // RAM output is masked outside DUMP_OUT so reset forces dump_data to zero at once.
    assign bus.dump_data = (state == DUMP_OUT)
                         ? {rd_byte[PLANE_R], rd_byte[PLANE_G], rd_byte[PLANE_B]}
                         : '0;
endmodule

// File: doc/image_writer.md
Name: image_writer

Overview:
- Write-side counterpart of the processor's vector image load path: takes 128-bit vector stores, each carrying 4 pixel lanes (one 8-bit pixel per 32-bit lane), and commits them to three byte-wide colour planes (R, G, B) holding the composited output image.
- A sequential dump port streams the finished image out as 24-bit RGB pixels to the host/display side.
- Sits on the data-memory bus beside the image ROM, decoded above the ROM's address range.

Parameters:
- PIXELS, 10000, pixels per colour plane.
- BASE_ADDR, 120000, first address of the R plane. G plane = BASE_ADDR+PIXELS; B plane = BASE_ADDR+2*PIXELS.
- LANES, 4, pixel lanes per vector word.

Ports:
- clk  in  1  system clock, posedge active.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  vector store request.
- addr  in  128  store address (pixel index in the global image map).
- wd  in  128  store data; lane k = wd[32k+31:32k], pixel value in the lane's low byte.
- busy  out  1  block cannot accept a store or dump start.
- dump_start  in  1  begin streaming the image.
- dump_valid  out  1  dump_data holds a valid pixel.
- dump_ready  in  1  sink accepts the pixel.
- dump_data  out  24  {R,G,B} of the current pixel.
- dump_done  out  1  one-cycle pulse with the last pixel's handshake.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, dump_valid=0, dump_data=0, dump_done=0; lane buffer and counters cleared. Plane RAM contents are not cleared.
- Decode: a store hits when BASE_ADDR <= addr <= BASE_ADDR+3*PIXELS-1. Plane = (addr-BASE_ADDR)/PIXELS; offset = remainder.
- All address arithmetic is done at 128 bits, with no truncation before comparison.
- FSM states: IDLE, WRITE, DUMP_RD, DUMP_OUT.
- IDLE:
  - A store is accepted at a posedge where we=1 and the address decodes to a hit. The edge latches plane, offset and the 4 lane bytes, and sets lane counter=0.
  - Next state is WRITE; busy=1 from the next cycle.
  - we=1 with a miss address is ignored; the state stays IDLE.
- WRITE:
  - One byte is written per cycle to plane[offset+lane], for lanes 0..3. The lane-3 write completes 4 edges after acceptance.
  - A lane whose offset+lane > PIXELS-1 is suppressed; there is no wrap into the next plane.
  - After lane 3, return to IDLE; busy=0 on the following cycle.
  - we asserted while busy=1 is ignored. The processor stalls on busy and re-presents the store.
- Simultaneous we (hit) and dump_start in IDLE: the store wins and dump_start is dropped.
- dump_start in IDLE with no store: index=0, go to DUMP_RD, busy=1 for the whole dump.
- DUMP_RD: issue a synchronous read of index on all three planes (1-cycle RAM latency), then go to DUMP_OUT.
- DUMP_OUT:
  - dump_valid=1; dump_data stays stable until a cycle with dump_ready=1.
  - On that handshake, if index=PIXELS-1: dump_done=1 for that cycle, dump_valid=0 next cycle, go to IDLE.
  - Otherwise index++ and go to DUMP_RD, so throughput is 1 pixel per 2 cycles.
- dump_start outside IDLE is ignored.
- Reset mid-write or mid-dump aborts immediately. Lanes already written remain in RAM; no dump_done is emitted.

Optional Feature:
- Macro: IMAGE_WRITER_SATURATE_EN.
- Defined: each lane's 32-bit value is treated as unsigned and clamped; values >255 are stored as 8'hFF.
- Undefined: lane value is truncated to bits [7:0].

Decomposition:
- Package img_pkg holds:
  - PIXELS and BASE_ADDR defaults;
  - plane index constants PLANE_R/G/B;
  - LANE_W=32 and PIX_W=8;
  - typedef enum logic [1:0] writer_state_t {IDLE, WRITE, DUMP_RD, DUMP_OUT}.
- Sub-module byte_plane_ram: single-port synchronous byte RAM of PIXELS depth, with one write-or-read per cycle. It is instantiated 3 times.

Test Plan:
- Store at addr=120000, wd lanes {0x11,0x22,0x33,0x44} -> busy=1 for 4 cycles. A dump then yields pixels 0..3 with R = 0x11,0x22,0x33,0x44; G,B unchanged.
- Store at addr=129998 (R plane, offset 9998) -> only offsets 9998 and 9999 of R are written. G offsets 0,1 are untouched.
- Lane value 0x00000123 -> stored as 0x23 without the macro, 0xFF with IMAGE_WRITER_SATURATE_EN.
- we=1 during busy, and store to addr=119999 -> both ignored; RAM is unchanged and the state stays IDLE/WRITE.
- Full dump with dump_ready toggling every other cycle -> exactly 10000 handshakes, dump_data stable while stalled, dump_done on the 10000th.
- rst_n low mid-dump at index 500 -> outputs are zero immediately. A new dump_start restarts at index 0.
